spike_ingress: RTL

Upstream feeder for `n_core`. It accepts a stream of spike addresses and end-of-timestep markers from the AER/router side over valid/ready, and buffers them in a small FIFO. It writes spikes into the core's input queue while honouring `full_input_queue`. At each timestep boundary it waits for the core to go idle, then issues a single-cycle `tick`, so the core integrates exactly one timestep per tick.

---
 rtl/spike_ingress_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/spike_ingress.sv | 97 +++++++++
 3 files changed

// File: rtl/spike_ingress_pkg.sv
// Shared types and default sizing for the spike ingress feeder.
// The FIFO beat layout and FSM state encoding live here so the top and the bench agree.
package spike_ingress_pkg;

  localparam int DEF_SPIKE_WIDTH = 8;
  localparam int DEF_BUF_DEPTH   = 16;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef struct packed {
    logic                       eot;
    logic [DEF_SPIKE_WIDTH-1:0] addr;
  } ingress_beat_t;

  typedef enum logic [1:0] {
    ST_FWD,
    ST_SETTLE,
    ST_WAIT_CORE,
    ST_TICK
  } ingress_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a peek at the entry behind the head.
// Pointers carry one extra bit so full and empty are told apart without a counter.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             multi_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic [AW:0]      w_rd_next;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_rd_next = r_rd_ptr + ONE;
  assign full_o    = (w_count == FULL_CNT);
  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign multi_o   = (w_count > ONE);
  assign head_o    = r_mem[r_rd_ptr[AW-1:0]];
  assign next_o    = r_mem[w_rd_next[AW-1:0]];
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + ONE;
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
    end
  end

endmodule

// File: rtl/spike_ingress.sv
// Feeds buffered spikes into n_core's input queue and paces timesteps with a one-cycle tick
// once the core has drained after each end-of-timestep marker.
module spike_ingress
  import spike_ingress_pkg::*;
#(
  parameter int SPIKE_WIDTH = DEF_SPIKE_WIDTH,
  parameter int BUF_DEPTH   = DEF_BUF_DEPTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [SPIKE_WIDTH-1:0] s_addr_i,
  input  logic                   s_eot_i,
  output logic                   wr_input_queue_o,
  output logic [SPIKE_WIDTH-1:0] wr_data_input_queue_o,
  input  logic                   full_input_queue_i,
  input  logic                   core_busy_i,
  output logic                   tick_o,
  output logic [CNT_WIDTH-1:0]   step_cnt_o,
  output logic [CNT_WIDTH-1:0]   spike_cnt_o
);

  ingress_state_t r_state, w_next_state;
  ingress_beat_t  w_in_beat, w_head, w_next;
  logic           w_full, w_empty, w_multi;
  logic           w_push, w_pop, w_head_valid, w_marker_next;
  logic [CNT_WIDTH-1:0] r_step_cnt, r_spike_cnt;

  assign w_in_beat    = {s_eot_i, s_addr_i};
  assign s_ready_o    = en_i & ~w_full & ~rst_i;
  assign w_push       = s_valid_i & s_ready_o;
  assign w_head_valid = ~w_empty;
  assign w_pop        = wr_input_queue_o | tick_o;

  sync_fifo #(
    .WIDTH ($bits(ingress_beat_t)),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_in_beat),
    .pop_i   (w_pop),
    .head_o  (w_head),
    .next_o  (w_next),
    .full_o  (w_full),
    .empty_o (w_empty),
    .multi_o (w_multi)
  );

  assign wr_input_queue_o      = (r_state == ST_FWD) & w_head_valid & ~w_head.eot
                                 & en_i & ~full_input_queue_i;
  assign wr_data_input_queue_o = w_head.addr;
  assign tick_o                = (r_state == ST_TICK) & en_i;

  // A marker about to reach the head moves us to SETTLE on that same edge, so SETTLE
  // coincides with the first cycle the marker sits at the head.
  assign w_marker_next = (w_head_valid & w_head.eot)
                       | (wr_input_queue_o & w_multi & w_next.eot)
                       | (wr_input_queue_o & ~w_multi & w_push & s_eot_i)
                       | (w_empty & w_push & s_eot_i);

  // NOTE: next-state gets its default first so no path through the case infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_FWD:       if (en_i & w_marker_next)  w_next_state = ST_SETTLE;
      ST_SETTLE:    if (en_i)                  w_next_state = ST_WAIT_CORE;
      ST_WAIT_CORE: if (en_i & ~core_busy_i)   w_next_state = ST_TICK;
      ST_TICK:      if (en_i)                  w_next_state = ST_FWD;
      default:                                 w_next_state = ST_FWD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_FWD;
      r_step_cnt  <= '0;
      r_spike_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (tick_o) begin
        r_step_cnt  <= r_step_cnt + CNT_WIDTH'(1);
        r_spike_cnt <= '0;
      end else if (wr_input_queue_o && r_spike_cnt != '1) begin
        r_spike_cnt <= r_spike_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign step_cnt_o  = r_step_cnt;
  assign spike_cnt_o = r_spike_cnt;

endmodule
